// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - RISC-V load/store funct3 size/sign codes
//   - responder FSM state encoding
//   - wait-state counter width
//   - legality check for a funct3 code given the access direction
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Loads accept the five RISC-V load codes. Stores accept only the
    // three unsigned-free size codes.
    function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
        logic ok;
        if (is_write)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for a 32-bit word-organised memory (combinational).
//   Store side: byte_off/funct3/wdata -> wr_be (byte enables) and wr_data
//               (store data replicated so every enabled lane carries it).
//   Load side:  rd_word (raw RAM word) -> rd_data, the addressed byte/half/
//               word moved to bit 0 and sign- or zero-extended.
// Ports:
//   byte_off  in  2   address bits [1:0]
//   funct3    in  3   RISC-V size/sign code
//   wdata     in  32  right-aligned store data
//   wr_be     out 4   byte enables for the RAM word
//   wr_data   out 32  lane-placed store data
//   rd_word   in  32  raw word read from the RAM
//   rd_data   out 32  extended load data
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [31:0] shifted;

    // Replicating the store data means lane i always finds its byte at
    // bit 8*i; the byte enables alone decide which lanes are written.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = wdata;
        case (funct3[1:0])
            2'd0: begin
                wr_be   = 4'b0001 << byte_off;
                wr_data = {4{wdata[7:0]}};
            end
            2'd1: begin
                wr_be   = byte_off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata;
            end
        endcase
    end

    assign shifted = rd_word >> {byte_off, 3'b000};

    always_comb begin
        rd_data = shifted;
        case (funct3)
            F3_B:    rd_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rd_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rd_data = {24'd0, shifted[7:0]};
            F3_HU:   rd_data = {16'd0, shifted[15:0]};
            default: rd_data = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port. Accepts one request
// at a time, waits WAIT_CYCLES extra cycles, performs the RAM access and
// presents the response until the core takes it.
// Ports:
//   clk         in  1   clock
//   reset       in  1   asynchronous active-low reset
//   req_valid   in  1   request present
//   req_ready   out 1   responder idle and able to accept
//   req_write   in  1   1 = store, 0 = load
//   req_funct3  in  3   RISC-V size/sign code
//   req_addr    in  32  byte address
//   req_wdata   in  32  right-aligned store data
//   rsp_valid   out 1   response present
//   rsp_ready   in  1   core accepts the response
//   rsp_rdata   out 32  extended load data, 0 for stores and errors
//   rsp_error   out 1   request rejected (range, alignment or funct3)
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH_WORDS * 4);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               capture;
    logic               access_en;

    logic               write_reg;
    logic [2:0]         funct3_reg;
    logic [31:0]        addr_reg;
    logic [31:0]        wdata_reg;

    logic [31:0]        offset;
    logic               req_err;
    logic [IDX_W-1:0]   word_idx;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic [31:0]        rd_word_reg;
    logic [31:0]        rd_ext;

    logic [31:0]        mem [DEPTH_WORDS];

    // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned
    // compare covers both ends of the window.
    assign offset   = addr_reg - BASE_ADDR;
    assign word_idx = offset[IDX_W+1:2];

    always_comb begin
        req_err = 1'b0;
        if (offset >= DEPTH_BYTES)
            req_err = 1'b1;
        if (!f3_legal(write_reg, funct3_reg))
            req_err = 1'b1;
        if (funct3_reg[1:0] == 2'd1 && addr_reg[0])
            req_err = 1'b1;
        if (funct3_reg[1:0] == 2'd2 && addr_reg[1:0] != 2'b00)
            req_err = 1'b1;
    end

    lsu_lane_align u_align (
        .byte_off (addr_reg[1:0]),
        .funct3   (funct3_reg),
        .wdata    (wdata_reg),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .rd_word  (rd_word_reg),
        .rd_data  (rd_ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Request fields are frozen at accept; the core may change its inputs
    // freely while the access is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_reg  <= 1'b0;
            funct3_reg <= 3'd0;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
        end else if (capture) begin
            write_reg  <= req_write;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        capture    = 1'b0;
        access_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    capture    = 1'b1;
                    cnt_next   = CNT_W'(WAIT_CYCLES);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    access_en  = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM array with registered read; no reset so it maps onto block RAM.
    // The write and the read sample both happen on the edge entering RESP,
    // and an aborted BUSY (reset) never reaches this edge.
    always_ff @(posedge clk) begin
        if (access_en && !req_err) begin
            if (write_reg) begin
                for (int i = 0; i < 4; i++) begin
                    if (wr_be[i])
                        mem[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end else begin
                rd_word_reg <= mem[word_idx];
            end
        end
    end

    // Response fields derive from registers that are stable throughout
    // RESP, so they hold while the core stalls.
    assign rsp_error = (state_reg == RESP) && req_err;
    assign rsp_rdata = ((state_reg == RESP) && !req_err && !write_reg) ? rd_ext : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          WAIT  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int unsigned vcyc;
        string       desc;
    } exp_t;
    exp_t sb_q[$];

    // Byte-addressed reference memory keyed by offset from BASE.
    logic [7:0] mdl [logic [31:0]];

    function automatic void model(input logic w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output logic err);
        logic [31:0] off;
        logic [31:0] val;
        logic [31:0] mask;
        int nb;
        logic legal;
        off = a - BASE;
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = w ? (f3 <= 3'd2)
                  : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err = !legal || ((a % nb) != 0) || (off >= 32'(DEPTH * 4));
        rd = 32'd0;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mdl[off + 32'(i)] = d[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < nb; i++) val[8*i +: 8] = mdl[off + 32'(i)];
                if (!f3[2] && nb < 4 && val[8*nb-1]) begin
                    mask = 32'hFFFF_FFFF << (8*nb);
                    val = val | mask;
                end
                rd = val;
            end
        end
    endfunction

    // Driver: present a request, hold it until accepted, push expectation.
    task automatic issue(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input string desc);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout %s: actual=req_ready 0 required=1", desc);
        end else begin
            model(w, f3, a, d, e.rd, e.err);
            e.vcyc = cyc + WAIT + 2;
            e.desc = desc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble the inputs so a design that keeps sampling them is caught.
        req_valid = 1'b0; req_write = $urandom_range(0, 1); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    // rsp_ready driver: 0 = random, 1 = held high, 2 = held low.
    int rdy_mode = 1;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'($urandom_range(0, 1));
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: checks latency on first valid, stability while stalled,
    // data/error at the handshake and req_ready after it.
    logic        in_resp = 1'b0;
    logic        chk_idle = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;
    always @(negedge clk) begin
        if (!reset) begin
            in_resp  = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                chk("req_ready_after_handshake", 32'(req_ready), 32'd1);
                chk_idle = 1'b0;
            end
            if (rsp_valid) begin
                chk("req_ready_low_in_resp", 32'(req_ready), 32'd0);
                if (!in_resp) begin
                    in_resp = 1'b1;
                    held_rdata = rsp_rdata;
                    held_err = rsp_error;
                    if (sb_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_rsp: actual=rsp_valid 1 required=0");
                    end else begin
                        chk({"latency ", sb_q[0].desc}, cyc, sb_q[0].vcyc);
                    end
                end else begin
                    chk("rdata_stable", rsp_rdata, held_rdata);
                    chk("error_stable", 32'(rsp_error), 32'(held_err));
                end
                if (rsp_ready) begin
                    if (sb_q.size() != 0) begin
                        chk({"rdata ", sb_q[0].desc}, rsp_rdata, sb_q[0].rd);
                        chk({"error ", sb_q[0].desc}, 32'(rsp_error), 32'(sb_q[0].err));
                        $display("RSP %s rdata=%h error=%0d", sb_q[0].desc, rsp_rdata, rsp_error);
                        void'(sb_q.pop_front());
                    end
                    in_resp = 1'b0;
                    chk_idle = 1'b1;
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].vcyc + 50) begin
                checks++; failures++;
                $display("FAIL rsp_timeout %s: actual=no response required=response", sb_q[0].desc);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        w;
        int          guard;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_error", 32'(rsp_error), 32'd0);

        // Preload the 16-word test window so every later load is defined.
        for (int i = 0; i < 16; i++)
            issue(1'b1, 3'd2, BASE + 32'(4*i), $urandom, "preload_sw");
        drain();

        issue(1'b1, 3'd2, 32'h0000_4010, 32'hDEAD_BEEF, "sw_deadbeef");
        issue(1'b0, 3'd2, 32'h0000_4010, 32'd0, "lw_deadbeef");
        issue(1'b1, 3'd0, 32'h0000_4011, 32'h0000_0080, "sb_80");
        issue(1'b0, 3'd0, 32'h0000_4011, 32'd0, "lb_sext");
        issue(1'b0, 3'd4, 32'h0000_4011, 32'd0, "lbu_zext");
        issue(1'b0, 3'd1, 32'h0000_4010, 32'd0, "lh_sext");
        issue(1'b0, 3'd2, 32'h0000_4002, 32'd0, "lw_misaligned");
        issue(1'b0, 3'd2, 32'h0000_3FFC, 32'd0, "lw_below_base");
        issue(1'b0, 3'd3, 32'h0000_4000, 32'd0, "load_f3_3");
        issue(1'b1, 3'd2, 32'h0000_5000, 32'hCAFE_F00D, "sw_beyond_end");
        issue(1'b0, 3'd2, 32'h0000_4000, 32'd0, "lw_base_unchanged");
        drain();

        // Stall the response for several cycles.
        rdy_mode = 2;
        @(posedge clk);
        issue(1'b0, 3'd2, 32'h0000_4010, 32'd0, "lw_stalled");
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
        rdy_mode = 1;
        drain();

        // Reset during the second BUSY cycle of a store.
        issue(1'b1, 3'd2, 32'h0000_4020, 32'd0, "sw_zero_4020");
        drain();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h0000_4020; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_req_ready", 32'(req_ready), 32'd1);
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_rsp_rdata", rsp_rdata, 32'd0);
        chk("midreset_rsp_error", 32'(rsp_error), 32'd0);
        $display("REQ sw_12345678 aborted by reset");
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 3'd2, 32'h0000_4020, 32'd0, "lw_after_abort");
        drain();

        // Randomised traffic with random response back-pressure.
        rdy_mode = 0;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'($urandom_range(1, 16));
                1:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 16));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1 && f3 == 3'd0) f3 = 3'd4;
            if ($urandom_range(0, 3) == 1 && f3 == 3'd1) f3 = 3'd5;
            w = 1'($urandom_range(0, 1));
            issue(w, f3, a, $urandom, w ? "rand_store" : "rand_load");
        end
        drain();
        rdy_mode = 1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
